// File: rtl/dmem_resp.sv
// Data-memory responder at the LSU end of the LSU-to-DMem interface: zero-latency line
// reads, bit-masked writes, a post-reset self-clear FSM and saturating access counters.
module dmem_resp #(
  parameter int MEM_WIDTH = 128,
  parameter int MEM_DEPTH = 512,
  parameter int ADDR_BIT  = 9,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BIT-1:0]  lsu_dmem_addr,
  input  logic                 lsu_dmem_ren,
  input  logic [MEM_WIDTH-1:0] lsu_dmem_extended_wen,
  input  logic [MEM_WIDTH-1:0] lsu_dmem_extended_wr_data,
  output logic [MEM_WIDTH-1:0] dmem_lsu_rd_data,
  output logic                 dmem_init_busy,
  output logic                 dmem_init_done,
  input  logic                 dmem_cnt_clr,
  output logic [CNT_WIDTH-1:0] dmem_rd_cnt,
  output logic [CNT_WIDTH-1:0] dmem_wr_cnt
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_BIT-1:0] LAST_LINE = ADDR_BIT'(MEM_DEPTH - 1);

  state_t                state, state_next;
  logic [ADDR_BIT-1:0]   clr_ptr;
  logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
  logic                  ready;
  logic                  rd_acc;
  logic                  wr_acc;

  assign ready  = (state == READY);
  assign rd_acc = ready && lsu_dmem_ren;
  assign wr_acc = ready && (|lsu_dmem_extended_wen);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) clr_ptr <= clr_ptr + ADDR_BIT'(1);
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (clr_ptr == LAST_LINE) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // Decoded straight from the state flop, so both flags are glitch-free register outputs.
  assign dmem_init_busy = (state == INIT);
  assign dmem_init_done = (state == READY);

  // NOTE: the array has no reset term; the INIT sweep zeroes it instead, keeping it RAM-mappable.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc) begin
      mem[lsu_dmem_addr] <= (mem[lsu_dmem_addr] & ~lsu_dmem_extended_wen)
                          | (lsu_dmem_extended_wr_data & lsu_dmem_extended_wen);
    end
  end

  // Combinational read sees the pre-edge line, so a same-cycle write is not forwarded.
  assign dmem_lsu_rd_data = rd_acc ? mem[lsu_dmem_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_rd_cnt <= '0;
      dmem_wr_cnt <= '0;
    end else if (dmem_cnt_clr) begin
      dmem_rd_cnt <= '0;
      dmem_wr_cnt <= '0;
    end else begin
      if (rd_acc && !(&dmem_rd_cnt)) dmem_rd_cnt <= dmem_rd_cnt + CNT_WIDTH'(1);
      if (wr_acc && !(&dmem_wr_cnt)) dmem_wr_cnt <= dmem_wr_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: reference memory/counter model with a read-data scoreboard,
// covering the clear sweep, masked writes, read-before-write, saturation and reset re-entry.
module tb_dmem_resp;

  localparam int W = 128;
  localparam int D = 512;
  localparam int A = 9;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [A-1:0] addr;
  logic         ren;
  logic [W-1:0] wen;
  logic [W-1:0] wdata;
  logic [W-1:0] rd_data;
  logic         init_busy;
  logic         init_done;
  logic         cnt_clr;
  logic [C-1:0] rd_cnt;
  logic [C-1:0] wr_cnt;

  always #5 clk = ~clk;

  dmem_resp #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_BIT(A), .CNT_WIDTH(C)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .lsu_dmem_addr             (addr),
    .lsu_dmem_ren              (ren),
    .lsu_dmem_extended_wen     (wen),
    .lsu_dmem_extended_wr_data (wdata),
    .dmem_lsu_rd_data          (rd_data),
    .dmem_init_busy            (init_busy),
    .dmem_init_done            (init_done),
    .dmem_cnt_clr              (cnt_clr),
    .dmem_rd_cnt               (rd_cnt),
    .dmem_wr_cnt               (wr_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] model_mem [D];
  logic [C-1:0] model_rd;
  logic [C-1:0] model_wr;
  bit           model_ready;

  localparam logic [W-1:0] ONES  = '1;
  localparam logic [W-1:0] BYTE0 = 128'hFF;
  localparam logic [W-1:0] PAT_A5 = {16{8'hA5}};

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_ready = 1'b0;
    model_rd    = '0;
    model_wr    = '0;
  endtask

  // One access cycle: drive after the edge, check at the falling edge, then
  // advance the model to what the following rising edge should commit.
  task automatic step(input string tag, input logic [A-1:0] a, input logic r,
                      input logic [W-1:0] m, input logic [W-1:0] d, input logic clr);
    @(posedge clk);
    #1;
    addr = a; ren = r; wen = m; wdata = d; cnt_clr = clr;
    exp_q.push_back((model_ready && r) ? model_mem[a] : '0);
    @(negedge clk);
    check({tag, "/rd_data"}, rd_data, exp_q.pop_front());
    check({tag, "/rd_cnt"}, W'(rd_cnt), W'(model_rd));
    check({tag, "/wr_cnt"}, W'(wr_cnt), W'(model_wr));
    if (clr) begin
      model_rd = '0;
      model_wr = '0;
    end else if (model_ready) begin
      if (r && model_rd != '1) model_rd++;
      if (|m && model_wr != '1) model_wr++;
    end
    if (model_ready && |m) model_mem[a] = (model_mem[a] & ~m) | (d & m);
  endtask

  task automatic idle();
    step("idle", '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Counts rising edges until init_busy drops, bounded so a stuck FSM still ends.
  task automatic init_wait(input string tag, input int start);
    int n = start;
    while (init_busy === 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "/init_cycles"}, W'(n), W'(D));
    check({tag, "/busy_low"}, W'(init_busy), W'(1'b0));
    check({tag, "/done_high"}, W'(init_done), W'(1'b1));
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    model_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; ren = 1'b1; wen = '0; wdata = '0; cnt_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset/busy", W'(init_busy), W'(1'b1));
    check("reset/done", W'(init_done), W'(1'b0));
    check("reset/rd_data", rd_data, '0);
    check("reset/rd_cnt", W'(rd_cnt), '0);
    ren = 1'b0;
    rst_n = 1'b1;

    // Write attempt during INIT must be dropped and left uncounted.
    for (int i = 0; i < 9; i++) idle();
    step("init_write", 9'd7, 1'b1, ONES, 128'h1234, 1'b0);
    idle();
    check("init/busy_mid", W'(init_busy), W'(1'b1));
    init_wait("init1", 11);

    step("rd_line0", 9'd0, 1'b1, '0, '0, 1'b0);
    step("rd_line511", 9'd511, 1'b1, '0, '0, 1'b0);
    step("rd_line7", 9'd7, 1'b1, '0, '0, 1'b0);

    // Byte-0 masked write, neighbours untouched.
    step("wr5_byte0", 9'd5, 1'b0, BYTE0, ONES, 1'b0);
    step("rd_line5", 9'd5, 1'b1, '0, '0, 1'b0);
    check("line5_byte0", rd_data, BYTE0);
    step("rd_line4", 9'd4, 1'b1, '0, '0, 1'b0);
    step("rd_line6", 9'd6, 1'b1, '0, '0, 1'b0);

    // Same-cycle read and full write returns the old line.
    step("rw5_same", 9'd5, 1'b1, ONES, PAT_A5, 1'b0);
    check("rw5_old", rd_data, BYTE0);
    step("rd5_new", 9'd5, 1'b1, '0, '0, 1'b0);
    check("rd5_a5", rd_data, PAT_A5);

    // Partial-mask merge on a non-zero line.
    step("wr5_merge", 9'd5, 1'b0, {{64{1'b0}}, {64{1'b1}}}, '0, 1'b0);
    step("rd5_merge", 9'd5, 1'b1, '0, '0, 1'b0);

    // Read counter saturation, then clear-over-increment priority.
    for (int i = 0; i < 20; i++) step("sat_rd", A'(i), 1'b1, '0, '0, 1'b0);
    check("rd_cnt_sat", W'(rd_cnt), W'(4'hF));
    step("clr_with_ren", 9'd1, 1'b1, '0, '0, 1'b1);
    step("single_ren", 9'd2, 1'b1, '0, '0, 1'b0);
    check("rd_cnt_cleared", W'(rd_cnt), W'(4'h0));
    idle();
    check("rd_cnt_one", W'(rd_cnt), W'(4'h1));

    step("wr9", 9'd9, 1'b0, ONES, 128'hDEAD_BEEF, 1'b0);
    idle();

    // Reset mid-READY: immediate return to INIT with counters cleared.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ready/busy", W'(init_busy), W'(1'b1));
    check("rst_ready/done", W'(init_done), W'(1'b0));
    check("rst_ready/wr_cnt", W'(wr_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset again at INIT cycle 300: the sweep restarts from line 0.
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("init2/busy_300", W'(init_busy), W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("rst_init/busy", W'(init_busy), W'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    init_wait("init3", 0);

    step("rd9_after_rst", 9'd9, 1'b1, '0, '0, 1'b0);
    check("line9_zero", rd_data, '0);
    step("rd5_after_rst", 9'd5, 1'b1, '0, '0, 1'b0);
    step("both_rw", 9'd3, 1'b1, ONES, PAT_A5, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
